stereo_pattern_source: RTL and testbench
========================================

// Module: stereo_pattern_source
// PURPOSE
// - Dual AXI4-Stream video master producing synchronized left/right test frames (tuser=SOF, tlast=EOL).
// - Drives the stereo pipeline inputs (rectification, disparity) on board and in simulation, without cameras.
// - R frame equals L frame shifted by a known horizontal disparity, so downstream disparity output is checkable.
// PARAMETERS
// - WIDTH       640   active pixels per line (multiple of NPPC)
// - HEIGHT      480   lines per frame
// - BPP         8     bits per pixel
// - NPPC        4     pixels per beat; AXIS_TDATA_WIDTH = BPP*NPPC
// - DISP        16    column offset applied to R pattern (0..WIDTH-1)
// - FRAME_GAP   64    idle cycles between frames (>=1)
// PORTS
// - aclk             in   1       clock
// - areset           in   1       asynchronous reset, active-high
// - enable           in   1       level; frames start only while high
// - pattern_sel      in   2       0 ramp, 1 vertical bars, 2 checker, 3 constant 0x80
// - m_axis_l_tvalid  out  1       L stream valid
// - m_axis_l_tdata   out  BPP*NPPC  L pixels, pixel i at [i*BPP +: BPP], pixel 0 = leftmost
// - m_axis_l_tready  in   1       L backpressure
// - m_axis_l_tlast   out  1       L last beat of line
// - m_axis_l_tuser   out  1       L first beat of frame
// - m_axis_r_*       same set for R stream
// - frame_cnt        out  16      completed frames (both channels), wraps at 2^16
// - busy             out  1       high from frame start to end of gap
// BEHAVIOUR
// - Reset (async assert, sync release): all tvalid/tlast/tuser=0, tdata=0, frame_cnt=0, busy=0, FSM=IDLE.
// - Top FSM: IDLE -> ACTIVE when enable=1 (1 cycle later tvalid=1 on both); ACTIVE -> GAP when both
//   channels DONE; GAP counts FRAME_GAP cycles -> ACTIVE if enable else IDLE. frame_cnt++ on ACTIVE->GAP.
// - pattern_sel and frame_cnt latched at frame start; changes mid-frame have no effect.
// - Channels independent within a frame: each has beat counter x (0..WIDTH/NPPC-1), line y (0..HEIGHT-1);
//   advance only on tvalid&&tready; after last beat the channel goes DONE (tvalid=0) and waits for the other.
// - AXIS master rules: tvalid never drops and tdata/tlast/tuser never change while tvalid&&!tready.
// - tuser=1 only on x=0,y=0; tlast=1 only on x=WIDTH/NPPC-1. Output registered; zero combinational path tready->tvalid.
// - Column c = x*NPPC+i; R uses cr = c+DISP (no wrap clip, value arithmetic mod 2^BPP); F = latched frame_cnt.
//   ramp: (c+y+F) mod 2^BPP; bars: ((c>>4)&1) ? max : 0; checker: (((c>>3)^(y>>3))&1) ? max : 0; const: 0x80.
// - enable low mid-frame: current frame completes, then IDLE after gap. Never a partial frame.
// - areset mid-frame: outputs drop immediately; next frame restarts at x=0,y=0 with tuser.
// - Simultaneous last beats on L and R: single ACTIVE->GAP transition, frame_cnt +1 only.
// STRUCTURE
// - Package stereo_stream_pkg: pattern_e enum, top state enum, function pattern_pixel(c,y,F,sel) returning BPP bits.
// - Sub-module stream_pattern_channel (x/y counters, output register, DONE flag; column offset as input),
//   instantiated twice (offset 0 and DISP); top holds FSM, gap counter, frame_cnt.
// TESTING (WIDTH=16, HEIGHT=4, NPPC=4, BPP=8, DISP=2, FRAME_GAP=4)
// - Reset, enable=1, sel=0, tready=1 -> first L beat 32'h03020100 tuser=1; R 32'h05040302; 16 beats/frame, tlast every 4th.
// - Random tready on L only -> L data stable while stalled; R finishes first, waits; next tuser after both done + 4 gap cycles.
// - sel=2 -> L row 0 beat 2 = 32'hFFFFFFFF, beat 0 = 32'h00000000; sel=3 -> all beats 32'h80808080.
// - sel changed 1->0 mid-frame -> current frame remains bars; next frame ramp with F=1 (first beat 32'h04030201).
// - enable=0 at beat 5 -> frame completes, frame_cnt=1, busy falls after gap, no further tvalid.
// - areset asserted at beat 7 with tready=0 -> tvalid=0 same cycle, frame_cnt=0; after release restarts with tuser=1.

Source files
------------

// File: rtl/stereo_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stereo_stream_pkg
// Description : Shared types and the test-pattern pixel function for the
//               stereo pattern source.
// Revision    : 1.0 - initial release
// ============================================================================
package stereo_stream_pkg;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_CONST   = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } top_state_e;

    localparam logic [31:0] C_PIX_CONST = 32'h0000_0080;

    // Pixel value for column c, line y, frame number f. The result is
    // computed 32 bits wide; callers keep the low BPP bits, which gives the
    // modulo-2^BPP ramp and an all-ones "max" for free.
    function automatic logic [31:0] pattern_pixel(
        input logic [31:0] c,
        input logic [31:0] y,
        input logic [15:0] f,
        input pattern_e    sel
    );
        logic [31:0] v;
        v = '0;
        case (sel)
            PAT_RAMP:    v = c + y + {16'd0, f};
            PAT_BARS:    v = c[4] ? '1 : '0;
            PAT_CHECKER: v = (c[3] ^ y[3]) ? '1 : '0;
            PAT_CONST:   v = C_PIX_CONST;
            default:     v = C_PIX_CONST;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_pattern_channel.sv
`default_nettype none
// ============================================================================
// Module      : stream_pattern_channel
// Description : One AXI4-Stream video channel: walks x/y over one frame,
//               holds a registered output beat, flags DONE after the last
//               beat. Column offset shifts the pattern horizontally.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pattern_channel
    import stereo_stream_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int BPP    = 8,
    parameter int NPPC   = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  pattern_e             sel,
    input  logic [15:0]          frame_f,
    input  logic [15:0]          col_offset,
    output logic                 tvalid,
    output logic [BPP*NPPC-1:0]  tdata,
    input  logic                 tready,
    output logic                 tlast,
    output logic                 tuser,
    output logic                 done
);

    localparam int BEATS = WIDTH / NPPC;
    localparam int XW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] C_X_LAST = XW'(BEATS - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic                  r_tvalid;
    logic [BPP*NPPC-1:0]   r_tdata;
    logic                  r_tlast;
    logic                  r_tuser;
    logic                  r_done;

    logic [XW-1:0]         w_ld_x;
    logic [YW-1:0]         w_ld_y;
    logic                  w_frame_end;
    logic [BPP*NPPC-1:0]   w_data;

    // Position of the beat to load next: origin on start, else the successor.
    always_comb begin
        w_ld_x = '0;
        w_ld_y = '0;
        if (!start) begin
            if (r_x == C_X_LAST) begin
                w_ld_x = '0;
                w_ld_y = r_y + YW'(1);
            end else begin
                w_ld_x = r_x + XW'(1);
                w_ld_y = r_y;
            end
        end
    end

    assign w_frame_end = (r_x == C_X_LAST) && (r_y == C_Y_LAST);

    generate
        for (genvar i = 0; i < NPPC; i++) begin : g_pix
            logic [31:0] w_col;
            assign w_col = 32'(w_ld_x) * 32'(NPPC) + 32'(i) + {16'd0, col_offset};
            assign w_data[i*BPP +: BPP] = BPP'(pattern_pixel(w_col, 32'(w_ld_y), frame_f, sel));
        end
    endgenerate

    // Output beat register: loads on start or on an accepted beat, holds while stalled.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_x      <= '0;
            r_y      <= '0;
            r_tvalid <= 1'b1;
            r_tdata  <= w_data;
            r_tlast  <= (C_X_LAST == '0);
            r_tuser  <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_tvalid && tready) begin
            if (w_frame_end) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_tuser  <= 1'b0;
                r_done   <= 1'b1;
            end else begin
                r_x      <= w_ld_x;
                r_y      <= w_ld_y;
                r_tdata  <= w_data;
                r_tlast  <= (w_ld_x == C_X_LAST);
                r_tuser  <= 1'b0;
            end
        end
    end

    assign tvalid = r_tvalid;
    assign tdata  = r_tdata;
    assign tlast  = r_tlast;
    assign tuser  = r_tuser;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: rtl/stereo_pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : stereo_pattern_source
// Description : Dual AXI4-Stream test-frame master. Left and right channels
//               carry the same pattern, right shifted by DISP columns.
//               Frame sequencing, inter-frame gap and frame counter live here.
// Revision    : 1.0 - initial release
// ============================================================================
module stereo_pattern_source
    import stereo_stream_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int BPP       = 8,
    parameter int NPPC      = 4,
    parameter int DISP      = 16,
    parameter int FRAME_GAP = 64
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    output logic                 m_axis_l_tvalid,
    output logic [BPP*NPPC-1:0]  m_axis_l_tdata,
    input  logic                 m_axis_l_tready,
    output logic                 m_axis_l_tlast,
    output logic                 m_axis_l_tuser,
    output logic                 m_axis_r_tvalid,
    output logic [BPP*NPPC-1:0]  m_axis_r_tdata,
    input  logic                 m_axis_r_tready,
    output logic                 m_axis_r_tlast,
    output logic                 m_axis_r_tuser,
    output logic [15:0]          frame_cnt,
    output logic                 busy
);

    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GW-1:0] C_GAP_LAST = GW'(FRAME_GAP - 1);

    logic [1:0]    r_rst_sync;
    logic          w_rst;
    top_state_e    r_state;
    logic          r_start;
    pattern_e      r_sel;
    logic [15:0]   r_frame_f;
    logic [15:0]   r_frame_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_busy;
    logic          w_done_l;
    logic          w_done_r;

    // Reset asserts asynchronously and releases two clocks after areset falls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    // Frame sequencer. r_start is a one-cycle pulse that loads both channels;
    // done flags from the previous frame are ignored while it is high.
    always_ff @(posedge aclk or posedge w_rst) begin
        if (w_rst) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_sel       <= PAT_RAMP;
            r_frame_f   <= '0;
            r_frame_cnt <= '0;
            r_gap_cnt   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state   <= ST_ACTIVE;
                        r_start   <= 1'b1;
                        r_sel     <= pattern_e'(pattern_sel);
                        r_frame_f <= r_frame_cnt;
                        r_busy    <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!r_start && w_done_l && w_done_r) begin
                        r_state     <= ST_GAP;
                        r_gap_cnt   <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == C_GAP_LAST) begin
                        if (enable) begin
                            r_state   <= ST_ACTIVE;
                            r_start   <= 1'b1;
                            r_sel     <= pattern_e'(pattern_sel);
                            r_frame_f <= r_frame_cnt;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    stream_pattern_channel #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .BPP    (BPP),
        .NPPC   (NPPC)
    ) u_chan_l (
        .aclk       (aclk),
        .areset     (w_rst),
        .start      (r_start),
        .sel        (r_sel),
        .frame_f    (r_frame_f),
        .col_offset (16'd0),
        .tvalid     (m_axis_l_tvalid),
        .tdata      (m_axis_l_tdata),
        .tready     (m_axis_l_tready),
        .tlast      (m_axis_l_tlast),
        .tuser      (m_axis_l_tuser),
        .done       (w_done_l)
    );

    stream_pattern_channel #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .BPP    (BPP),
        .NPPC   (NPPC)
    ) u_chan_r (
        .aclk       (aclk),
        .areset     (w_rst),
        .start      (r_start),
        .sel        (r_sel),
        .frame_f    (r_frame_f),
        .col_offset (16'(DISP)),
        .tvalid     (m_axis_r_tvalid),
        .tdata      (m_axis_r_tdata),
        .tready     (m_axis_r_tready),
        .tlast      (m_axis_r_tlast),
        .tuser      (m_axis_r_tuser),
        .done       (w_done_r)
    );

    assign frame_cnt = r_frame_cnt;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stereo_pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_stereo_pattern_source
// Description : Directed self-checking bench for stereo_pattern_source
//               (16x4 frame, 4 pixels/beat, disparity 2, gap 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stereo_pattern_source;

    logic        clk;
    logic        areset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        tvalid_l, tready_l, tlast_l, tuser_l;
    logic        tvalid_r, tready_r, tlast_r, tuser_r;
    logic [31:0] tdata_l, tdata_r;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] lbeats [16];

    stereo_pattern_source #(
        .WIDTH(16), .HEIGHT(4), .BPP(8), .NPPC(4), .DISP(2), .FRAME_GAP(4)
    ) dut (
        .aclk            (clk),
        .areset          (areset),
        .enable          (enable),
        .pattern_sel     (pattern_sel),
        .m_axis_l_tvalid (tvalid_l),
        .m_axis_l_tdata  (tdata_l),
        .m_axis_l_tready (tready_l),
        .m_axis_l_tlast  (tlast_l),
        .m_axis_l_tuser  (tuser_l),
        .m_axis_r_tvalid (tvalid_r),
        .m_axis_r_tdata  (tdata_r),
        .m_axis_r_tready (tready_r),
        .m_axis_r_tlast  (tlast_r),
        .m_axis_r_tuser  (tuser_r),
        .frame_cnt       (frame_cnt),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pixel for the 8-bit patterns.
    function automatic logic [7:0] exp_pix(input int c, input int y, input int f, input int sel);
        logic [31:0] s;
        s = c + y + f;
        case (sel)
            0:       return s[7:0];
            1:       return (((c >> 4) & 1) != 0) ? 8'hFF : 8'h00;
            2:       return ((((c >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [31:0] exp_beat(input int idx, input int off, input int sel, input int f);
        logic [31:0] b;
        int x;
        int y;
        x = idx % 4;
        y = idx / 4;
        b = '0;
        for (int i = 0; i < 4; i++) b[i*8 +: 8] = exp_pix(x*4 + i + off, y, f, sel);
        return b;
    endfunction

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!tvalid_l && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, tvalid_l, 1);
    endtask

    // Negedges with tvalid_l low from the end of a frame to the next frame's first beat.
    task automatic measure_gap(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!tvalid_l && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, exp_n);
    endtask

    // Consume one full frame on both channels, checking every beat. Entered on a
    // negedge; returns on the negedge after the final handshake.
    task automatic capture_frame(input int sel, input int f, input bit stall_l, input int drop_en_at);
        int bl;
        int br;
        bit held;
        bit idle_checked;
        logic [34:0] hold;
        bl = 0;
        br = 0;
        held = 1'b0;
        idle_checked = 1'b0;
        hold = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (bl == 16 && br == 16) break;
            if (held) check("l_stall_hold", {tvalid_l, tlast_l, tuser_l, tdata_l}, hold);
            if (br == 16 && bl < 16 && !idle_checked) begin
                check("r_done_idle", tvalid_r, 0);
                idle_checked = 1'b1;
            end
            tready_l = stall_l ? 1'($urandom_range(0, 1)) : 1'b1;
            tready_r = 1'b1;
            if (tvalid_l && tready_l) begin
                check($sformatf("l_beat%0d", bl), {tlast_l, tuser_l, tdata_l},
                      {(bl % 4 == 3), (bl == 0), exp_beat(bl, 0, sel, f)});
                lbeats[bl] = tdata_l;
                bl++;
                if (bl == drop_en_at) enable = 1'b0;
            end
            held = tvalid_l && !tready_l;
            hold = {tvalid_l, tlast_l, tuser_l, tdata_l};
            if (tvalid_r && tready_r) begin
                check($sformatf("r_beat%0d", br), {tlast_r, tuser_r, tdata_r},
                      {(br % 4 == 3), (br == 0), exp_beat(br, 2, sel, f)});
                br++;
            end
            @(negedge clk);
        end
        check("l_beat_count", bl, 16);
        check("r_beat_count", br, 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        areset = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd0;
        tready_l = 1'b0;
        tready_r = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_l", {tvalid_l, tlast_l, tuser_l, tdata_l}, 0);
        check("rst_r", {tvalid_r, tlast_r, tuser_r, tdata_r}, 0);
        check("rst_cnt_busy", {frame_cnt, busy}, 0);

        // Frame 0: ramp, F=0, no backpressure
        areset = 1'b0;
        enable = 1'b1;
        wait_valid("s1_start");
        check("first_l", {tuser_l, tdata_l}, {1'b1, 32'h03020100});
        check("first_r", {tuser_r, tdata_r}, {1'b1, 32'h05040302});
        check("first_busy", busy, 1);
        capture_frame(0, 0, 1'b0, -1);
        // 1 cycle to see both done, 4 gap cycles, 1 cycle start->tvalid
        measure_gap("gap0", 6);
        check("cnt_after_f0", {frame_cnt, busy}, {16'd1, 1'b1});

        // Frame 1: ramp F=1 latched already; sel change mid-frame ignored; L stalls randomly
        pattern_sel = 2'd2;
        capture_frame(0, 1, 1'b1, -1);
        check("f1_first_beat", lbeats[0], 32'h04030201);
        measure_gap("gap1", 6);
        check("cnt_after_f1", frame_cnt, 2);

        // Frame 2: checker
        pattern_sel = 2'd3;
        capture_frame(2, 2, 1'b0, -1);
        check("chk_row0_beat2", lbeats[2], 32'hFFFFFFFF);
        check("chk_row0_beat0", lbeats[0], 32'h00000000);
        measure_gap("gap2", 6);

        // Frame 3: constant
        capture_frame(3, 3, 1'b0, -1);
        check("const_beat5", lbeats[5], 32'h80808080);

        // Bars frame with sel switched to ramp after it starts
        areset = 1'b1;
        @(negedge clk);
        check("rst2_valid", {tvalid_l, tvalid_r, frame_cnt}, 0);
        areset = 1'b0;
        pattern_sel = 2'd1;
        enable = 1'b1;
        wait_valid("s4_start");
        pattern_sel = 2'd0;
        capture_frame(1, 0, 1'b0, -1);
        measure_gap("gap_bars", 6);
        check("ramp_f1_first", {tuser_l, tdata_l}, {1'b1, 32'h04030201});

        // enable drops at beat 5: frame completes, then idle after the gap
        capture_frame(0, 1, 1'b0, 5);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_fall", n, 5);
        check("cnt_after_drop", frame_cnt, 2);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | tvalid_l | tvalid_r;
        end
        check("no_restart", {seen, busy}, 0);

        // areset mid-frame at beat 7 with tready low
        enable = 1'b1;
        pattern_sel = 2'd0;
        wait_valid("s5_start");
        tready_l = 1'b1;
        tready_r = 1'b1;
        repeat (7) @(negedge clk);
        tready_l = 1'b0;
        tready_r = 1'b0;
        check("beat7_l", {tlast_l, tdata_l}, {1'b1, exp_beat(7, 0, 0, 2)});
        #2 areset = 1'b1;
        #1;
        check("async_rst_valid", {tvalid_l, tvalid_r}, 0);
        check("async_rst_cnt", {frame_cnt, busy}, 0);
        @(negedge clk);
        areset = 1'b0;
        wait_valid("s5_restart");
        check("restart_first", {tuser_l, tdata_l}, {1'b1, 32'h03020100});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
